// File: rtl/lfsr_word_gen.sv
// Fibonacci LFSR word generator: mix, collect OUT_W MSBs serially, present; first word 1+MIX_CYCLES+OUT_W edges after enable.
// Backpressure: a presented word and valid_flag hold (LFSR frozen) until out_ready; seed_load discards it.
module lfsr_word_gen #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'h9,
    parameter logic [WIDTH-1:0] SEED       = 4'hB,
    parameter int               OUT_W      = 4,
    parameter int               MIX_CYCLES = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_flag,
    output logic             lockup_flag
);

    localparam int CNT_MAX    = (MIX_CYCLES > OUT_W) ? MIX_CYCLES : OUT_W;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int MIX_LAST_I = (MIX_CYCLES > 0) ? MIX_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] MIX_LAST = CNT_W'(MIX_LAST_I);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MIX     = 2'd1,
        COLLECT = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Where a new word starts: the mix phase vanishes entirely when MIX_CYCLES is 0.
    localparam state_t RUN_START = (MIX_CYCLES == 0) ? COLLECT : MIX;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] shreg_q, shreg_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;

    logic             fb;
    logic [WIDTH-1:0] lfsr_adv;
    logic [OUT_W-1:0] shreg_nxt;

    always_comb begin
        fb        = ^(lfsr_q & TAPS);
        lfsr_adv  = {lfsr_q[WIDTH-2:0], fb};
        shreg_nxt = {shreg_q[OUT_W-2:0], lfsr_q[WIDTH-1]};

        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        lock_d  = 1'b0;

        if (seed_load) begin
            // An all-zero seed would lock the register up, so fall back to SEED and flag it.
            if (seed_in == '0) begin
                lfsr_d = SEED;
                lock_d = 1'b1;
            end else begin
                lfsr_d = seed_in;
            end
            cnt_d   = '0;
            shreg_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
            state_d = RUN_START;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = RUN_START;
                    end
                end
                MIX: begin
                    if (enable) begin
                        lfsr_d = lfsr_adv;
                        if (cnt_q == MIX_LAST) begin
                            cnt_d   = '0;
                            state_d = COLLECT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                COLLECT: begin
                    if (enable) begin
                        lfsr_d  = lfsr_adv;
                        shreg_d = shreg_nxt;
                        if (cnt_q == OUT_LAST) begin
                            cnt_d   = '0;
                            shreg_d = '0;
                            data_d  = shreg_nxt;
                            valid_d = 1'b1;
                            state_d = PRESENT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        data_d  = '0;
                        valid_d = 1'b0;
                        state_d = RUN_START;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
        end
    end

    assign data_out    = data_q;
    assign valid_flag  = valid_q;
    assign lockup_flag = lock_q;

endmodule
